// File: rtl/enc_selector.sv
// Stages message symbols from a beat-wide source and places a requested count into rotated output lanes.
// Output placement is registered one cycle after the pop. in_ready depends only on registered occupancy.
module enc_selector #(
  parameter int SYM_WID = 8,
  parameter int SYM_NUM = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [SYM_NUM*SYM_WID-1:0]       in_data,
  input  logic                             con_stall,
  input  logic [$clog2(SYM_NUM+1)-1:0]     sel_request,
  input  logic [$clog2(SYM_NUM)-1:0]       sel_offset,
  output logic [SYM_NUM*SYM_WID-1:0]       out_data,
  output logic [SYM_NUM-1:0]               out_mask,
  output logic                             out_valid,
  output logic                             err_underflow
);

  localparam int BUF_DEP = 2 * SYM_NUM;
  localparam int CNT_W   = $clog2(BUF_DEP + 1);
  localparam int OFF_W   = $clog2(SYM_NUM);

  typedef logic [SYM_WID-1:0] sym_t;

  sym_t                            buf_q [BUF_DEP];
  sym_t                            buf_d [BUF_DEP];
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [SYM_NUM-1:0][SYM_WID-1:0] out_data_q, out_data_d;
  logic [SYM_NUM-1:0]              out_mask_q, out_mask_d;
  logic                            out_valid_q, out_valid_d;
  logic                            err_q, err_d;

  logic [CNT_W-1:0] req_ext;
  logic [CNT_W-1:0] pop_amt;
  logic [CNT_W-1:0] base;
  logic             pop_elig;
  logic             underflow;
  logic             push;

  assign in_ready  = (cnt_q <= CNT_W'(SYM_NUM));
  assign push      = in_valid && in_ready;
  assign req_ext   = CNT_W'(sel_request);
  assign pop_elig  = !con_stall && (sel_request != '0);
  assign underflow = pop_elig && (req_ext > cnt_q);
  assign pop_amt   = (pop_elig && !underflow) ? req_ext : '0;
  assign base      = cnt_q - pop_amt;

  // Shift out the popped symbols, then append the beat behind what remains.
  always_comb begin
    for (int i = 0; i < BUF_DEP; i++) begin
      buf_d[i] = '0;
      for (int p = 0; p <= SYM_NUM; p++) begin
        if (pop_amt == CNT_W'(p) && (i + p) < BUF_DEP) begin
          buf_d[i] = buf_q[i + p];
        end
      end
    end
    if (push) begin
      for (int b = 0; b <= SYM_NUM; b++) begin
        if (base == CNT_W'(b)) begin
          for (int j = 0; j < SYM_NUM; j++) begin
            buf_d[b + j] = in_data[j*SYM_WID +: SYM_WID];
          end
        end
      end
    end
    cnt_d = base + (push ? CNT_W'(SYM_NUM) : CNT_W'(0));
  end

  always_comb begin
    logic [OFF_W-1:0] lane;
    lane        = '0;
    out_data_d  = '0;
    out_mask_d  = '0;
    out_valid_d = (pop_amt != '0);
    err_d       = err_q | underflow;
    if (con_stall) begin
      out_data_d = out_data_q;
      out_mask_d = out_mask_q;
    end else begin
      for (int k = 0; k < SYM_NUM; k++) begin
        if (CNT_W'(k) < pop_amt) begin
          // Offset sum wraps naturally because SYM_NUM is a power of two.
          lane             = sel_offset + OFF_W'(k);
          out_data_d[lane] = buf_q[k];
          out_mask_d[lane] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEP; i++) begin
        buf_q[i] <= '0;
      end
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_mask_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      for (int i = 0; i < BUF_DEP; i++) begin
        buf_q[i] <= buf_d[i];
      end
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_mask_q  <= out_mask_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign out_data      = out_data_q;
  assign out_mask      = out_mask_q;
  assign out_valid     = out_valid_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_enc_selector.sv
// Bench for enc_selector: directed vector table, hand-written underflow/reset sequence, randomized model check.
module tb_enc_selector;

  localparam int SW = 8;
  localparam int SN = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic          con_stall;
  logic [2:0]    sel_request;
  logic [1:0]    sel_offset;
  logic [31:0]   out_data;
  logic [3:0]    out_mask;
  logic          out_valid;
  logic          err_underflow;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  enc_selector #(.SYM_WID(SW), .SYM_NUM(SN)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .con_stall(con_stall), .sel_request(sel_request), .sel_offset(sel_offset),
    .out_data(out_data), .out_mask(out_mask), .out_valid(out_valid),
    .err_underflow(err_underflow)
  );

  typedef struct {
    logic        vld;
    logic [31:0] dat;
    logic        stall;
    logic [2:0]  req;
    logic [1:0]  off;
    logic [31:0] e_data;
    logic [3:0]  e_mask;
    logic        e_valid;
    logic        e_rdy;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(input logic vld, input logic [31:0] dat, input logic stall,
                              input logic [2:0] req, input logic [1:0] off,
                              input logic [31:0] e_data, input logic [3:0] e_mask,
                              input logic e_valid, input logic e_rdy, input logic [3:0] e_cnt);
    vec_t v;
    v.vld = vld; v.dat = dat; v.stall = stall; v.req = req; v.off = off;
    v.e_data = e_data; v.e_mask = e_mask; v.e_valid = e_valid; v.e_rdy = e_rdy; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic vld, input logic [31:0] dat, input logic stall,
                       input logic [2:0] req, input logic [1:0] off);
    in_valid    = vld;
    in_data     = dat;
    con_stall   = stall;
    sel_request = req;
    sel_offset  = off;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    drive(1'b0, 32'h0, 1'b0, 3'd0, 2'd0);
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask

  // Reference model state: a plain symbol queue plus the registered output image.
  logic [7:0]  mq[$];
  logic [31:0] m_data;
  logic [3:0]  m_mask;
  logic        m_valid;
  logic        m_err;

  task automatic model_clear;
    mq.delete();
    m_data = '0; m_mask = '0; m_valid = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step(input logic vld, input logic [31:0] dat, input logic stall,
                            input int req, input int off);
    bit push;
    push = vld && (mq.size() <= SN);
    if (!stall && req != 0) begin
      m_data = '0; m_mask = '0; m_valid = 1'b0;
      if (req <= mq.size()) begin
        for (int k = 0; k < req; k++) begin
          int lane;
          lane = (off + k) % SN;
          m_data[lane*SW +: SW] = mq.pop_front();
          m_mask[lane] = 1'b1;
        end
        m_valid = 1'b1;
      end else begin
        m_err = 1'b1;
      end
    end else if (stall) begin
      m_valid = 1'b0;
    end else begin
      m_data = '0; m_mask = '0; m_valid = 1'b0;
    end
    if (push) begin
      for (int j = 0; j < SN; j++) mq.push_back(dat[j*SW +: SW]);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 3'd0, 2'd0);
    #12;
    chk("rst_data", out_data, 32'h0);
    chk("rst_mask", {28'h0, out_mask}, 32'h0);
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_err", {31'h0, err_underflow}, 32'h0);
    chk("rst_ready", {31'h0, in_ready}, 32'h1);
    tick;
    rst = 1'b0;

    //                vld   dat           stl   req   off   e_data        e_mask e_vld e_rdy e_cnt
    tbl[0]  = mk(1'b1, 32'h13121110, 1'b0, 3'd0, 2'd0, 32'h00000000, 4'h0, 1'b0, 1'b1, 4'd4);
    tbl[1]  = mk(1'b1, 32'h23222120, 1'b0, 3'd0, 2'd0, 32'h00000000, 4'h0, 1'b0, 1'b0, 4'd8);
    tbl[2]  = mk(1'b0, 32'h00000000, 1'b0, 3'd4, 2'd0, 32'h13121110, 4'hF, 1'b1, 1'b1, 4'd4);
    tbl[3]  = mk(1'b0, 32'h00000000, 1'b0, 3'd3, 2'd2, 32'h21200022, 4'hD, 1'b1, 1'b1, 4'd1);
    tbl[4]  = mk(1'b0, 32'h00000000, 1'b0, 3'd1, 2'd1, 32'h00002300, 4'h2, 1'b1, 1'b1, 4'd0);
    tbl[5]  = mk(1'b1, 32'h13121110, 1'b0, 3'd0, 2'd0, 32'h00000000, 4'h0, 1'b0, 1'b1, 4'd4);
    tbl[6]  = mk(1'b1, 32'h33323130, 1'b0, 3'd2, 2'd0, 32'h00001110, 4'h3, 1'b1, 1'b0, 4'd6);
    tbl[7]  = mk(1'b0, 32'h00000000, 1'b0, 3'd2, 2'd0, 32'h00001312, 4'h3, 1'b1, 1'b1, 4'd4);
    tbl[8]  = mk(1'b0, 32'h00000000, 1'b0, 3'd1, 2'd3, 32'h30000000, 4'h8, 1'b1, 1'b1, 4'd3);
    tbl[9]  = mk(1'b0, 32'h00000000, 1'b0, 3'd3, 2'd0, 32'h00333231, 4'h7, 1'b1, 1'b1, 4'd0);
    tbl[10] = mk(1'b1, 32'h13121110, 1'b0, 3'd0, 2'd0, 32'h00000000, 4'h0, 1'b0, 1'b1, 4'd4);
    tbl[11] = mk(1'b1, 32'h23222120, 1'b0, 3'd4, 2'd0, 32'h13121110, 4'hF, 1'b1, 1'b1, 4'd4);
    tbl[12] = mk(1'b1, 32'h33323130, 1'b1, 3'd4, 2'd0, 32'h13121110, 4'hF, 1'b0, 1'b0, 4'd8);
    tbl[13] = mk(1'b1, 32'h33323130, 1'b1, 3'd4, 2'd0, 32'h13121110, 4'hF, 1'b0, 1'b0, 4'd8);
    tbl[14] = mk(1'b0, 32'h00000000, 1'b1, 3'd4, 2'd2, 32'h13121110, 4'hF, 1'b0, 1'b0, 4'd8);
    tbl[15] = mk(1'b0, 32'h00000000, 1'b0, 3'd4, 2'd1, 32'h22212023, 4'hF, 1'b1, 1'b1, 4'd4);
    tbl[16] = mk(1'b0, 32'h00000000, 1'b0, 3'd0, 2'd0, 32'h00000000, 4'h0, 1'b0, 1'b1, 4'd4);

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].vld, tbl[i].dat, tbl[i].stall, tbl[i].req, tbl[i].off);
      tick;
      chk($sformatf("vec%0d_data", i), out_data, tbl[i].e_data);
      chk($sformatf("vec%0d_mask", i), {28'h0, out_mask}, {28'h0, tbl[i].e_mask});
      chk($sformatf("vec%0d_valid", i), {31'h0, out_valid}, {31'h0, tbl[i].e_valid});
      chk($sformatf("vec%0d_ready", i), {31'h0, in_ready}, {31'h0, tbl[i].e_rdy});
      chk($sformatf("vec%0d_cnt", i), {28'h0, dut.cnt_q}, {28'h0, tbl[i].e_cnt});
      chk($sformatf("vec%0d_err", i), {31'h0, err_underflow}, 32'h0);
    end

    // Underflow is sticky and leaves occupancy untouched.
    drive(1'b0, 32'h0, 1'b0, 3'd2, 2'd0); tick;
    chk("uf_pre_data", out_data, 32'h00003130);
    chk("uf_pre_cnt", {28'h0, dut.cnt_q}, 32'd2);
    drive(1'b0, 32'h0, 1'b0, 3'd3, 2'd1); tick;
    chk("uf_err", {31'h0, err_underflow}, 32'h1);
    chk("uf_mask", {28'h0, out_mask}, 32'h0);
    chk("uf_data", out_data, 32'h0);
    chk("uf_valid", {31'h0, out_valid}, 32'h0);
    chk("uf_cnt", {28'h0, dut.cnt_q}, 32'd2);
    drive(1'b0, 32'h0, 1'b0, 3'd0, 2'd0); tick;
    chk("uf_sticky", {31'h0, err_underflow}, 32'h1);
    drive(1'b0, 32'h0, 1'b0, 3'd2, 2'd2); tick;
    chk("uf_after_data", out_data, 32'h33320000);
    chk("uf_after_mask", {28'h0, out_mask}, 32'hC);
    chk("uf_after_err", {31'h0, err_underflow}, 32'h1);
    drive(1'b1, 32'h13121110, 1'b0, 3'd0, 2'd0); tick;
    drive(1'b1, 32'h23222120, 1'b0, 3'd4, 2'd0); tick;
    chk("pre_rst_data", out_data, 32'h13121110);

    // Asynchronous reset mid-cycle clears everything at once.
    drive(1'b1, 32'h33323130, 1'b0, 3'd0, 2'd0);
    #2 rst = 1'b1;
    #1;
    chk("arst_data", out_data, 32'h0);
    chk("arst_mask", {28'h0, out_mask}, 32'h0);
    chk("arst_valid", {31'h0, out_valid}, 32'h0);
    chk("arst_err", {31'h0, err_underflow}, 32'h0);
    chk("arst_ready", {31'h0, in_ready}, 32'h1);
    chk("arst_cnt", {28'h0, dut.cnt_q}, 32'h0);
    tick;
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 3'd1, 2'd0); tick;
    chk("empty_uf_err", {31'h0, err_underflow}, 32'h1);
    chk("empty_uf_valid", {31'h0, out_valid}, 32'h0);

    // Randomized run against the queue model, with periodic resets.
    for (int blk = 0; blk < 4; blk++) begin
      do_reset;
      model_clear;
      for (int c = 0; c < 600; c++) begin
        logic        vld, stall;
        logic [31:0] dat;
        int          req, off;
        vld   = ($urandom_range(0, 99) < 55);
        stall = ($urandom_range(0, 99) < 20);
        dat   = $urandom;
        req   = $urandom_range(0, SN);
        off   = $urandom_range(0, SN - 1);
        chk("rnd_ready", {31'h0, in_ready}, {31'h0, (mq.size() <= SN)});
        drive(vld, dat, stall, 3'(req), 2'(off));
        model_step(vld, dat, stall, req, off);
        tick;
        chk("rnd_data", out_data, m_data);
        chk("rnd_mask", {28'h0, out_mask}, {28'h0, m_mask});
        chk("rnd_valid", {31'h0, out_valid}, {31'h0, m_valid});
        chk("rnd_err", {31'h0, err_underflow}, {31'h0, m_err});
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
